// File: rtl/count_sequencer_pkg.sv
// Shared types for the count sequencer: host command op codes and FSM states.
package count_sequencer_pkg;

  typedef enum logic [1:0] {
    OP_START  = 2'd0,
    OP_STOP   = 2'd1,
    OP_PAUSE  = 2'd2,
    OP_RESUME = 2'd3
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_e;

endpackage

// File: rtl/count_sequencer_if.sv
// Host-side command channel and status outputs of the count sequencer.
interface count_sequencer_if #(
  parameter int unsigned N = 4
);
  import count_sequencer_pkg::*;

  logic          cmd_valid;
  logic          cmd_ready;
  cmd_op_e       cmd_op;
  logic [N-1:0]  cmd_start;
  logic [N-1:0]  cmd_limit;
  logic          cmd_reload;
  logic [N-1:0]  count;
  logic          busy;
  logic          paused;
  logic          done;
  logic          err;

  modport master (
    output cmd_valid, cmd_op, cmd_start, cmd_limit, cmd_reload,
    input  cmd_ready, count, busy, paused, done, err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_start, cmd_limit, cmd_reload,
    output cmd_ready, count, busy, paused, done, err
  );

endinterface

// File: rtl/count_sequencer_step_counter.sv
// N-bit counter register with synchronous load and a fixed +STEP increment.
module step_counter #(
  parameter int unsigned N    = 4,
  parameter int unsigned STEP = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         en,
  output logic [N-1:0] q
);

  if (STEP < 1 || STEP > (1 << N) - 1) begin : g_step_check
    $error("step_counter: STEP must be in 1..2^N-1");
  end

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = q_q + N'(STEP);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_sequencer.sv
// Command-driven controller: START/STOP/PAUSE/RESUME over a step counter,
// with clamp or auto-reload at the programmed limit.
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned STEP = 2
) (
  input  logic              clk,
  input  logic              reset,
  count_sequencer_if.slave  cmd
);

  state_e       state_q, state_d;
  logic [N-1:0] start_q, start_d;
  logic [N-1:0] limit_q, limit_d;
  logic         reload_q, reload_d;
  logic         ready_q;
  logic         done_q, done_d;
  logic         err_q, err_d;

  logic [N-1:0] count;
  logic [N-1:0] rem;
  logic         terminal;
  logic         accept;
  logic         load;
  logic [N-1:0] load_val;
  logic         en;

  assign accept   = cmd.cmd_valid & ready_q;
  assign rem      = limit_q - count;
  assign terminal = (rem < N'(STEP));

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    limit_d  = limit_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    load     = 1'b0;
    load_val = cmd.cmd_start;
    en       = 1'b0;

    if (accept) begin
      // An accepted command always wins over counting, even on a terminal cycle.
      unique case (cmd.cmd_op)
        OP_START: begin
          if (state_q == ST_IDLE) begin
            state_d  = ST_RUN;
            start_d  = cmd.cmd_start;
            limit_d  = cmd.cmd_limit;
            reload_d = cmd.cmd_reload;
            load     = 1'b1;
            load_val = cmd.cmd_start;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_STOP: begin
          if (state_q != ST_IDLE) state_d = ST_IDLE;
          else                    err_d   = 1'b1;
        end
        OP_PAUSE: begin
          if (state_q == ST_RUN) state_d = ST_PAUSED;
          else                   err_d   = 1'b1;
        end
        OP_RESUME: begin
          if (state_q == ST_PAUSED) state_d = ST_RUN;
          else                      err_d   = 1'b1;
        end
        default: err_d = 1'b1;
      endcase
    end else if (state_q == ST_RUN) begin
      if (terminal) begin
        done_d = 1'b1;
        load   = 1'b1;
        if (reload_q) begin
          load_val = start_q;
        end else begin
          load_val = limit_q;
          state_d  = ST_IDLE;
        end
      end else begin
        en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      start_q  <= '0;
      limit_q  <= '0;
      reload_q <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      limit_q  <= limit_d;
      reload_q <= reload_d;
      ready_q  <= 1'b1;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  step_counter #(
    .N    (N),
    .STEP (STEP)
  ) u_step_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .q        (count)
  );

  assign cmd.count     = count;
  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = (state_q != ST_IDLE);
  assign cmd.paused    = (state_q == ST_PAUSED);
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Directed bench for count_sequencer (N=4, STEP=2) with hand-computed expectations.
module tb_count_sequencer;
  import count_sequencer_pkg::*;

  logic clk;
  logic reset;
  int   pass_cnt;
  int   total_cnt;

  count_sequencer_if #(.N(4)) cif ();

  count_sequencer #(
    .N    (4),
    .STEP (2)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .cmd   (cif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input cmd_op_e op, input logic [3:0] s, input logic [3:0] l,
                       input logic r);
    cif.cmd_op     = op;
    cif.cmd_start  = s;
    cif.cmd_limit  = l;
    cif.cmd_reload = r;
    cif.cmd_valid  = 1'b1;
    tick();
    cif.cmd_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total_cnt++;
    if ({cif.count, cif.busy, cif.paused, cif.done, cif.err, cif.cmd_ready} !== 9'b0)
      $display("FAIL reset_state: got count=%0d busy=%b paused=%b done=%b err=%b ready=%b want all 0",
               cif.count, cif.busy, cif.paused, cif.done, cif.err, cif.cmd_ready);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (cif.cmd_ready !== 1'b1)
      $display("FAIL reset_ready: got %b want 1", cif.cmd_ready);
    else pass_cnt++;
  endtask

  task automatic test_exact_limit();
    logic [3:0] exp_c [5] = '{4'd2, 4'd4, 4'd6, 4'd6, 4'd6};
    logic       exp_d [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_b [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    issue(OP_START, 4'd0, 4'd6, 1'b0);
    total_cnt++;
    if (cif.count !== 4'd0 || cif.busy !== 1'b1)
      $display("FAIL exact_start: got count=%0d busy=%b want 0/1", cif.count, cif.busy);
    else pass_cnt++;
    for (int unsigned i = 0; i < 5; i++) begin
      tick();
      total_cnt++;
      if (cif.count !== exp_c[i] || cif.done !== exp_d[i] || cif.busy !== exp_b[i])
        $display("FAIL exact_step%0d: got count=%0d done=%b busy=%b want %0d/%b/%b",
                 i, cif.count, cif.done, cif.busy, exp_c[i], exp_d[i], exp_b[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_clamp();
    logic [3:0] exp_c [4] = '{4'd2, 4'd4, 4'd5, 4'd5};
    logic       exp_d [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       exp_b [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    issue(OP_START, 4'd0, 4'd5, 1'b0);
    total_cnt++;
    if (cif.count !== 4'd0)
      $display("FAIL clamp_start: got count=%0d want 0", cif.count);
    else pass_cnt++;
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      total_cnt++;
      if (cif.count !== exp_c[i] || cif.done !== exp_d[i] || cif.busy !== exp_b[i])
        $display("FAIL clamp_step%0d: got count=%0d done=%b busy=%b want %0d/%b/%b",
                 i, cif.count, cif.done, cif.busy, exp_c[i], exp_d[i], exp_b[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reload_wrap();
    logic [3:0] exp_c [6] = '{4'd0, 4'd2, 4'd14, 4'd0, 4'd2, 4'd14};
    logic       exp_d [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    issue(OP_START, 4'd14, 4'd2, 1'b1);
    total_cnt++;
    if (cif.count !== 4'd14 || cif.busy !== 1'b1)
      $display("FAIL reload_start: got count=%0d busy=%b want 14/1", cif.count, cif.busy);
    else pass_cnt++;
    for (int unsigned i = 0; i < 6; i++) begin
      tick();
      total_cnt++;
      if (cif.count !== exp_c[i] || cif.done !== exp_d[i] || cif.busy !== 1'b1)
        $display("FAIL reload_step%0d: got count=%0d done=%b busy=%b want %0d/%b/1",
                 i, cif.count, cif.done, cif.busy, exp_c[i], exp_d[i]);
      else pass_cnt++;
    end
    issue(OP_STOP, 4'd0, 4'd0, 1'b0);
    total_cnt++;
    if (cif.count !== 4'd14 || cif.busy !== 1'b0 || cif.done !== 1'b0 || cif.err !== 1'b0)
      $display("FAIL reload_stop: got count=%0d busy=%b done=%b err=%b want 14/0/0/0",
               cif.count, cif.busy, cif.done, cif.err);
    else pass_cnt++;
  endtask

  task automatic test_pause_resume();
    issue(OP_START, 4'd0, 4'd10, 1'b0);
    tick();
    tick();
    total_cnt++;
    if (cif.count !== 4'd4 || cif.paused !== 1'b0)
      $display("FAIL pause_pre: got count=%0d paused=%b want 4/0", cif.count, cif.paused);
    else pass_cnt++;
    issue(OP_PAUSE, 4'd0, 4'd0, 1'b0);
    for (int unsigned i = 0; i < 3; i++) begin
      total_cnt++;
      if (cif.count !== 4'd4 || cif.paused !== 1'b1 || cif.busy !== 1'b1)
        $display("FAIL pause_hold%0d: got count=%0d paused=%b busy=%b want 4/1/1",
                 i, cif.count, cif.paused, cif.busy);
      else pass_cnt++;
      if (i < 2) tick();
    end
    issue(OP_RESUME, 4'd0, 4'd0, 1'b0);
    total_cnt++;
    if (cif.count !== 4'd4 || cif.paused !== 1'b0 || cif.err !== 1'b0)
      $display("FAIL resume: got count=%0d paused=%b err=%b want 4/0/0",
               cif.count, cif.paused, cif.err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cif.count !== 4'd6)
      $display("FAIL resume_adv: got count=%0d want 6", cif.count);
    else pass_cnt++;
    issue(OP_RESUME, 4'd0, 4'd0, 1'b0);
    total_cnt++;
    if (cif.err !== 1'b1 || cif.count !== 4'd6)
      $display("FAIL resume_in_run: got err=%b count=%0d want 1/6", cif.err, cif.count);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cif.err !== 1'b0 || cif.count !== 4'd8)
      $display("FAIL resume_in_run_after: got err=%b count=%0d want 0/8", cif.err, cif.count);
    else pass_cnt++;
    issue(OP_STOP, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic test_illegal();
    issue(OP_START, 4'd0, 4'd6, 1'b0);
    issue(OP_START, 4'd8, 4'd12, 1'b0);
    total_cnt++;
    if (cif.err !== 1'b1 || cif.count !== 4'd0 || cif.busy !== 1'b1 || cif.done !== 1'b0)
      $display("FAIL start_in_run: got err=%b count=%0d busy=%b done=%b want 1/0/1/0",
               cif.err, cif.count, cif.busy, cif.done);
    else pass_cnt++;
    tick();
    tick();
    tick();
    total_cnt++;
    if (cif.err !== 1'b0 || cif.count !== 4'd6)
      $display("FAIL start_in_run_after: got err=%b count=%0d want 0/6", cif.err, cif.count);
    else pass_cnt++;
    // count==limit: this is the terminal cycle, STOP must suppress done
    issue(OP_STOP, 4'd0, 4'd0, 1'b0);
    total_cnt++;
    if (cif.done !== 1'b0 || cif.busy !== 1'b0 || cif.count !== 4'd6 || cif.err !== 1'b0)
      $display("FAIL stop_terminal: got done=%b busy=%b count=%0d err=%b want 0/0/6/0",
               cif.done, cif.busy, cif.count, cif.err);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cif.done !== 1'b0)
      $display("FAIL stop_terminal_after: got done=%b want 0", cif.done);
    else pass_cnt++;
    issue(OP_PAUSE, 4'd0, 4'd0, 1'b0);
    total_cnt++;
    if (cif.err !== 1'b1 || cif.busy !== 1'b0 || cif.paused !== 1'b0)
      $display("FAIL pause_in_idle: got err=%b busy=%b paused=%b want 1/0/0",
               cif.err, cif.busy, cif.paused);
    else pass_cnt++;
    issue(OP_STOP, 4'd0, 4'd0, 1'b0);
    total_cnt++;
    if (cif.err !== 1'b1 || cif.busy !== 1'b0)
      $display("FAIL stop_in_idle: got err=%b busy=%b want 1/0", cif.err, cif.busy);
    else pass_cnt++;
  endtask

  task automatic test_start_eq_limit();
    issue(OP_START, 4'd3, 4'd3, 1'b0);
    total_cnt++;
    if (cif.count !== 4'd3 || cif.done !== 1'b0 || cif.busy !== 1'b1)
      $display("FAIL eq_start: got count=%0d done=%b busy=%b want 3/0/1",
               cif.count, cif.done, cif.busy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (cif.count !== 4'd3 || cif.done !== 1'b1 || cif.busy !== 1'b0)
      $display("FAIL eq_done: got count=%0d done=%b busy=%b want 3/1/0",
               cif.count, cif.done, cif.busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    issue(OP_START, 4'd0, 4'd14, 1'b0);
    for (int unsigned i = 0; i < 4; i++) tick();
    total_cnt++;
    if (cif.count !== 4'd8)
      $display("FAIL mid_pre: got count=%0d want 8", cif.count);
    else pass_cnt++;
    reset = 1'b1;
    cif.cmd_op    = OP_STOP;
    cif.cmd_valid = 1'b1;
    tick();
    cif.cmd_valid = 1'b0;
    total_cnt++;
    if (cif.count !== 4'd0 || cif.busy !== 1'b0 || cif.cmd_ready !== 1'b0 ||
        cif.done !== 1'b0 || cif.err !== 1'b0)
      $display("FAIL mid_reset: got count=%0d busy=%b ready=%b done=%b err=%b want 0/0/0/0/0",
               cif.count, cif.busy, cif.cmd_ready, cif.done, cif.err);
    else pass_cnt++;
    reset = 1'b0;
    tick();
    total_cnt++;
    if (cif.cmd_ready !== 1'b1 || cif.busy !== 1'b0 || cif.err !== 1'b0)
      $display("FAIL mid_ready: got ready=%b busy=%b err=%b want 1/0/0",
               cif.cmd_ready, cif.busy, cif.err);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt       = 0;
    total_cnt      = 0;
    reset          = 1'b1;
    cif.cmd_valid  = 1'b0;
    cif.cmd_op     = OP_START;
    cif.cmd_start  = '0;
    cif.cmd_limit  = '0;
    cif.cmd_reload = 1'b0;
    test_reset();
    test_exact_limit();
    test_clamp();
    test_reload_wrap();
    test_pause_resume();
    test_illegal();
    test_start_eq_limit();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
